// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: data-memory port between the MIPS MEM stage and a word-wide
// synchronous RAM. Handles byte/half/word loads and stores with byte enables,
// load sign/zero extension and a req/ack handshake that stalls the CPU.
// Misaligned, out-of-range or malformed requests are flagged on cpu_err instead
// of being issued to memory.
// Optional feature: define DMEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT
// cycles without mem_ack (cpu_err pulse, cpu_rdata = 0).
module dmem_port_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [1:0]        cpu_size,
   input  logic              cpu_unsigned,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_write_val,
   input  logic [31:0]       mem_read_val,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_read_en_q, mem_read_en_d;
   logic              mem_write_en_q, mem_write_en_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [31:0]       mem_write_val_q, mem_write_val_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              cpu_err_q, cpu_err_d;
   // Access shape kept for the lane select when read data returns
   logic [1:0]        lane_q, lane_d;
   logic [1:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;

   logic              req;
   logic              acc_err;
   logic              range_err;
   logic              stall_raw;
   logic [3:0]        be_calc;
   logic [31:0]       wval_calc;
   logic [7:0]        load_byte;
   logic [15:0]       load_half;
   logic [31:0]       load_ext;
   logic              timeout_hit;

   assign req       = cpu_read | cpu_write;
   // Any address bit above the implemented word space makes the access illegal
   assign range_err = (cpu_addr >> (ADDR_W + 2)) != 32'd0;

   // Classify the incoming request as legal or not
   always_comb begin
      acc_err = 1'b0;
      if (cpu_read & cpu_write)                        acc_err = 1'b1;
      if (cpu_size == 2'b11)                           acc_err = 1'b1;
      if ((cpu_size == 2'b01) && cpu_addr[0])          acc_err = 1'b1;
      if ((cpu_size == 2'b10) && (cpu_addr[1:0] != 2'b00)) acc_err = 1'b1;
      if (range_err)                                   acc_err = 1'b1;
   end

   // Byte enables and lane-replicated store data for the incoming request
   always_comb begin
      be_calc   = 4'b0000;
      wval_calc = cpu_wdata;
      case (cpu_size)
         2'b00: begin
            be_calc   = 4'b0001 << cpu_addr[1:0];
            wval_calc = {4{cpu_wdata[7:0]}};
         end
         2'b01: begin
            be_calc   = cpu_addr[1] ? 4'b1100 : 4'b0011;
            wval_calc = {2{cpu_wdata[15:0]}};
         end
         2'b10: begin
            be_calc   = 4'b1111;
            wval_calc = cpu_wdata;
         end
         default: begin
            be_calc   = 4'b0000;
            wval_calc = cpu_wdata;
         end
      endcase
   end

   // Select the addressed lane of the returned word and extend it
   always_comb begin
      load_byte = mem_read_val[{lane_q, 3'b000} +: 8];
      load_half = lane_q[1] ? mem_read_val[31:16] : mem_read_val[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{~unsigned_q & load_byte[7]}}, load_byte};
         2'b01:   load_ext = {{16{~unsigned_q & load_half[15]}}, load_half};
         default: load_ext = mem_read_val;
      endcase
   end

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

   assign timeout_hit = (busy_cnt_q == CNT_W'(TIMEOUT - 1));

   // BUSY cycle counter: cleared on BUSY entry, advances while waiting for ack
   always_comb begin
      busy_cnt_d = busy_cnt_q;
      if (state_q == ST_IDLE) begin
         busy_cnt_d = '0;
      end else if ((state_q == ST_BUSY) && !mem_ack && !timeout_hit) begin
         busy_cnt_d = busy_cnt_q + 1'b1;
      end
   end

   // BUSY cycle counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt_q <= '0;
      end else begin
         busy_cnt_q <= busy_cnt_d;
      end
   end
`else
   logic unused_timeout;

   // Without the watchdog a BUSY access waits for mem_ack indefinitely
   assign timeout_hit    = 1'b0;
   assign unused_timeout = (TIMEOUT < 0);
`endif

   // Next-state and registered-output logic of the access FSM
   always_comb begin
      state_d         = state_q;
      mem_addr_d      = mem_addr_q;
      mem_read_en_d   = mem_read_en_q;
      mem_write_en_d  = mem_write_en_q;
      mem_be_d        = mem_be_q;
      mem_write_val_d = mem_write_val_q;
      cpu_rdata_d     = cpu_rdata_q;
      cpu_err_d       = 1'b0;
      lane_d          = lane_q;
      size_d          = size_q;
      unsigned_d      = unsigned_q;
      stall_raw       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall_raw = req & ~acc_err;
            if (req && acc_err) begin
               cpu_err_d = 1'b1;
            end else if (req) begin
               mem_addr_d      = cpu_addr[ADDR_W+1:2];
               mem_be_d        = be_calc;
               mem_write_val_d = wval_calc;
               mem_read_en_d   = cpu_read;
               mem_write_en_d  = cpu_write;
               lane_d          = cpu_addr[1:0];
               size_d          = cpu_size;
               unsigned_d      = cpu_unsigned;
               state_d         = ST_BUSY;
            end
         end
         ST_BUSY: begin
            stall_raw = 1'b1;
            if (mem_ack) begin
               mem_read_en_d  = 1'b0;
               mem_write_en_d = 1'b0;
               if (mem_read_en_q) begin
                  cpu_rdata_d = load_ext;
               end
               state_d = ST_DONE;
            end else if (timeout_hit) begin
               mem_read_en_d  = 1'b0;
               mem_write_en_d = 1'b0;
               cpu_rdata_d    = 32'd0;
               cpu_err_d      = 1'b1;
               state_d        = ST_DONE;
            end
         end
         ST_DONE: begin
            // Requests still asserted here belong to the access just completed
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered memory/CPU outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         mem_addr_q      <= '0;
         mem_read_en_q   <= 1'b0;
         mem_write_en_q  <= 1'b0;
         mem_be_q        <= 4'b0000;
         mem_write_val_q <= 32'd0;
         cpu_rdata_q     <= 32'd0;
         cpu_err_q       <= 1'b0;
         lane_q          <= 2'b00;
         size_q          <= 2'b00;
         unsigned_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         mem_addr_q      <= mem_addr_d;
         mem_read_en_q   <= mem_read_en_d;
         mem_write_en_q  <= mem_write_en_d;
         mem_be_q        <= mem_be_d;
         mem_write_val_q <= mem_write_val_d;
         cpu_rdata_q     <= cpu_rdata_d;
         cpu_err_q       <= cpu_err_d;
         lane_q          <= lane_d;
         size_q          <= size_d;
         unsigned_q      <= unsigned_d;
      end
   end

   // Stall is forced low while reset is held so the pipeline is released at once
   assign cpu_stall     = stall_raw & rst_n;
   assign cpu_rdata     = cpu_rdata_q;
   assign cpu_err       = cpu_err_q;
   assign mem_addr      = mem_addr_q;
   assign mem_read_en   = mem_read_en_q;
   assign mem_write_en  = mem_write_en_q;
   assign mem_be        = mem_be_q;
   assign mem_write_val = mem_write_val_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb_dmem_port_ctrl: directed self-checking bench for dmem_port_ctrl
// (ADDR_W=8, TIMEOUT=16). Define DMEM_TIMEOUT_EN for both files to exercise
// the watchdog; otherwise a slow-ack access is checked instead.
module tb_dmem_port_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_read;
   logic        cpu_write;
   logic [1:0]  cpu_size;
   logic        cpu_unsigned;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_err;
   logic [7:0]  mem_addr;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [3:0]  mem_be;
   logic [31:0] mem_write_val;
   logic [31:0] mem_read_val;
   logic        mem_ack;

   int checks;
   int failures;

   // Observations gathered by do_access
   int          stall_cnt;
   int          strobe_cnt;
   logic        finished;
   logic [7:0]  obs_addr;
   logic [3:0]  obs_be;
   logic [31:0] obs_wval;
   logic        obs_rd;
   logic        obs_wr;
   logic [31:0] obs_rdata;
   logic        obs_err;

   dmem_port_ctrl #(
      .ADDR_W  (8),
      .TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_read      (cpu_read),
      .cpu_write     (cpu_write),
      .cpu_size      (cpu_size),
      .cpu_unsigned  (cpu_unsigned),
      .cpu_rdata     (cpu_rdata),
      .cpu_stall     (cpu_stall),
      .cpu_err       (cpu_err),
      .mem_addr      (mem_addr),
      .mem_read_en   (mem_read_en),
      .mem_write_en  (mem_write_en),
      .mem_be        (mem_be),
      .mem_write_val (mem_write_val),
      .mem_read_val  (mem_read_val),
      .mem_ack       (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Run one access; ack arrives in BUSY cycle number ack_delay+1
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                            input logic [31:0] rv, input int ack_delay, input int bound);
      @(negedge clk);
      cpu_read     = rd;
      cpu_write    = wr;
      cpu_addr     = addr;
      cpu_size     = sz;
      cpu_unsigned = uns;
      cpu_wdata    = wd;
      mem_read_val = rv;
      mem_ack      = 1'b0;
      stall_cnt    = 0;
      strobe_cnt   = 0;
      finished     = 1'b0;
      obs_addr     = '0;
      obs_be       = '0;
      obs_wval     = '0;
      obs_rd       = 1'b0;
      obs_wr       = 1'b0;
      obs_rdata    = '0;
      obs_err      = 1'b0;
      #1;
      for (int c = 0; c < bound && !finished; c++) begin
         if (cpu_stall) stall_cnt++;
         if (mem_read_en || mem_write_en) begin
            if (strobe_cnt == 0) begin
               obs_addr = mem_addr;
               obs_be   = mem_be;
               obs_wval = mem_write_val;
               obs_rd   = mem_read_en;
               obs_wr   = mem_write_en;
            end
            strobe_cnt++;
            mem_ack = (strobe_cnt > ack_delay);
         end else begin
            mem_ack = 1'b0;
         end
         @(negedge clk);
         #1;
         if (!cpu_stall) begin
            finished  = 1'b1;
            obs_rdata = cpu_rdata;
            obs_err   = cpu_err;
         end
      end
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      mem_ack   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({cpu_stall, cpu_err, mem_read_en, mem_write_en} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=0000", {cpu_stall, cpu_err, mem_read_en, mem_write_en});
      end
      checks++;
      if ({mem_addr, mem_be} !== 12'h000) begin
         failures++;
         $display("FAIL reset_addr_be got=%h want=000", {mem_addr, mem_be});
      end
      checks++;
      if ({cpu_rdata, mem_write_val} !== 64'd0) begin
         failures++;
         $display("FAIL reset_data got=%h want=0", {cpu_rdata, mem_write_val});
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_store_word();
      do_access(1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 0, 20);
      checks++;
      if (finished !== 1'b1) begin
         failures++;
         $display("FAIL sw_complete got=%b want=1", finished);
      end
      checks++;
      if (obs_addr !== 8'h04 || obs_be !== 4'b1111) begin
         failures++;
         $display("FAIL sw_addr_be got=%h/%b want=04/1111", obs_addr, obs_be);
      end
      checks++;
      if (obs_wval !== 32'hDEADBEEF || obs_wr !== 1'b1 || obs_rd !== 1'b0) begin
         failures++;
         $display("FAIL sw_strobe got=%h wr=%b rd=%b want=deadbeef 1 0", obs_wval, obs_wr, obs_rd);
      end
      checks++;
      if (strobe_cnt !== 1 || stall_cnt !== 2) begin
         failures++;
         $display("FAIL sw_timing got strobe=%0d stall=%0d want 1 2", strobe_cnt, stall_cnt);
      end
      $display("SW 0x10: addr=%h be=%b wval=%h stall=%0d", obs_addr, obs_be, obs_wval, stall_cnt);
   endtask

   task automatic test_loads();
      do_access(1'b1, 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'h80FF_0000, 0, 20);
      checks++;
      if (obs_rdata !== 32'hFFFFFF80 || obs_be !== 4'b1000 || obs_addr !== 8'h04) begin
         failures++;
         $display("FAIL lb got=%h be=%b addr=%h want=ffffff80 1000 04", obs_rdata, obs_be, obs_addr);
      end
      $display("LB 0x13: rdata=%h", obs_rdata);
      do_access(1'b1, 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 32'h80FF_0000, 0, 20);
      checks++;
      if (obs_rdata !== 32'h00000080) begin
         failures++;
         $display("FAIL lbu got=%h want=00000080", obs_rdata);
      end
      $display("LBU 0x13: rdata=%h", obs_rdata);
      do_access(1'b1, 1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 32'h1234_8001, 0, 20);
      checks++;
      if (obs_rdata !== 32'h00008001 || obs_be !== 4'b0011) begin
         failures++;
         $display("FAIL lhu got=%h be=%b want=00008001 0011", obs_rdata, obs_be);
      end
      $display("LHU 0x10: rdata=%h", obs_rdata);
      do_access(1'b1, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'h80FF_0000, 0, 20);
      checks++;
      if (obs_rdata !== 32'hFFFF80FF || obs_be !== 4'b1100 || obs_rd !== 1'b1) begin
         failures++;
         $display("FAIL lh got=%h be=%b rd=%b want=ffff80ff 1100 1", obs_rdata, obs_be, obs_rd);
      end
      $display("LH 0x12: rdata=%h", obs_rdata);
   endtask

   task automatic test_store_sub();
      do_access(1'b0, 1'b1, 32'h06, 2'b01, 1'b0, 32'h0000_1234, 32'h0, 0, 20);
      checks++;
      if (obs_be !== 4'b1100 || obs_wval !== 32'h12341234 || obs_addr !== 8'h01) begin
         failures++;
         $display("FAIL sh got be=%b wval=%h addr=%h want=1100 12341234 01", obs_be, obs_wval, obs_addr);
      end
      $display("SH 0x06: be=%b wval=%h", obs_be, obs_wval);
      do_access(1'b0, 1'b1, 32'h05, 2'b00, 1'b0, 32'h0000_00AB, 32'h5555_5555, 0, 20);
      checks++;
      if (obs_be !== 4'b0010 || obs_wval !== 32'hABABABAB) begin
         failures++;
         $display("FAIL sb got be=%b wval=%h want=0010 abababab", obs_be, obs_wval);
      end
      // A store leaves the last load result in place
      checks++;
      if (obs_rdata !== 32'hFFFF80FF) begin
         failures++;
         $display("FAIL store_keeps_rdata got=%h want=ffff80ff", obs_rdata);
      end
      $display("SB 0x05: be=%b wval=%h rdata=%h", obs_be, obs_wval, obs_rdata);
   endtask

   task automatic test_errors();
      logic        e_rd [5];
      logic        e_wr [5];
      logic [31:0] e_addr [5];
      logic [1:0]  e_size [5];
      e_rd[0] = 1'b1; e_wr[0] = 1'b0; e_addr[0] = 32'h002; e_size[0] = 2'b10; // LW misaligned
      e_rd[1] = 1'b1; e_wr[1] = 1'b0; e_addr[1] = 32'h001; e_size[1] = 2'b01; // LH misaligned
      e_rd[2] = 1'b1; e_wr[2] = 1'b1; e_addr[2] = 32'h010; e_size[2] = 2'b10; // read+write
      e_rd[3] = 1'b1; e_wr[3] = 1'b0; e_addr[3] = 32'h400; e_size[3] = 2'b10; // out of range
      e_rd[4] = 1'b0; e_wr[4] = 1'b1; e_addr[4] = 32'h008; e_size[4] = 2'b11; // illegal size
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cpu_read  = e_rd[i];
         cpu_write = e_wr[i];
         cpu_addr  = e_addr[i];
         cpu_size  = e_size[i];
         #1;
         checks++;
         if (cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL err%0d_stall got=%b want=0", i, cpu_stall);
         end
         @(negedge clk);
         #1;
         checks++;
         if (cpu_err !== 1'b1 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
            failures++;
            $display("FAIL err%0d_pulse got err=%b rd=%b wr=%b want=1 0 0", i, cpu_err, mem_read_en, mem_write_en);
         end
         cpu_read  = 1'b0;
         cpu_write = 1'b0;
         @(negedge clk);
         #1;
         checks++;
         if (cpu_err !== 1'b0) begin
            failures++;
            $display("FAIL err%0d_clear got=%b want=0", i, cpu_err);
         end
         $display("error case %0d addr=%h size=%b: err pulse seen", i, e_addr[i], e_size[i]);
      end
   endtask

   task automatic test_long_ack();
      do_access(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 3, 20);
      checks++;
      if (obs_rdata !== 32'hCAFEF00D || stall_cnt !== 5 || obs_addr !== 8'h08) begin
         failures++;
         $display("FAIL lw_slow got=%h stall=%0d addr=%h want=cafef00d 5 08", obs_rdata, stall_cnt, obs_addr);
      end
      $display("LW 0x20 ack+3: rdata=%h stall=%0d", obs_rdata, stall_cnt);
   endtask

   task automatic test_stray_ack();
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({cpu_stall, cpu_err, mem_read_en, mem_write_en} !== 4'b0000 || cpu_rdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL stray_ack got=%b rdata=%h want=0000 cafef00d",
                  {cpu_stall, cpu_err, mem_read_en, mem_write_en}, cpu_rdata);
      end
      mem_ack = 1'b0;
      $display("stray ack in IDLE ignored");
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      cpu_read  = 1'b1;
      cpu_addr  = 32'h40;
      cpu_size  = 2'b10;
      mem_ack   = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (mem_read_en !== 1'b1 || cpu_stall !== 1'b1) begin
         failures++;
         $display("FAIL rst_busy_pre got rd=%b stall=%b want=1 1", mem_read_en, cpu_stall);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cpu_stall, mem_read_en, mem_write_en} !== 3'b000 || mem_addr !== 8'h00 || cpu_rdata !== 32'd0) begin
         failures++;
         $display("FAIL rst_busy got=%b addr=%h rdata=%h want=000 00 0",
                  {cpu_stall, mem_read_en, mem_write_en}, mem_addr, cpu_rdata);
      end
      @(negedge clk);
      cpu_read = 1'b0;
      rst_n    = 1'b1;
      do_access(1'b1, 1'b0, 32'h44, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, 0, 20);
      checks++;
      if (obs_rdata !== 32'h0BADF00D || stall_cnt !== 2 || obs_addr !== 8'h11) begin
         failures++;
         $display("FAIL lw_after_rst got=%h stall=%0d addr=%h want=0badf00d 2 11", obs_rdata, stall_cnt, obs_addr);
      end
      $display("reset during BUSY, then LW 0x44: rdata=%h", obs_rdata);
   endtask

`ifdef DMEM_TIMEOUT_EN
   task automatic test_timeout();
      do_access(1'b1, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h1111_2222, 1000, 60);
      checks++;
      if (finished !== 1'b1 || strobe_cnt !== 16 || stall_cnt !== 17) begin
         failures++;
         $display("FAIL timeout_len got fin=%b strobe=%0d stall=%0d want=1 16 17", finished, strobe_cnt, stall_cnt);
      end
      checks++;
      if (obs_err !== 1'b1 || obs_rdata !== 32'd0) begin
         failures++;
         $display("FAIL timeout_err got err=%b rdata=%h want=1 0", obs_err, obs_rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_err !== 1'b0 || cpu_stall !== 1'b0) begin
         failures++;
         $display("FAIL timeout_idle got err=%b stall=%b want=0 0", cpu_err, cpu_stall);
      end
      $display("timeout: strobe cycles=%0d err=%b", strobe_cnt, obs_err);
   endtask
`else
   task automatic test_slow_ack();
      do_access(1'b1, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h1111_2222, 20, 60);
      checks++;
      if (finished !== 1'b1 || stall_cnt !== 22 || obs_err !== 1'b0 || obs_rdata !== 32'h11112222) begin
         failures++;
         $display("FAIL slow_ack got fin=%b stall=%0d err=%b rdata=%h want=1 22 0 11112222",
                  finished, stall_cnt, obs_err, obs_rdata);
      end
      $display("LW 0x30 ack+20: stall=%0d rdata=%h", stall_cnt, obs_rdata);
   endtask
`endif

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      cpu_addr     = '0;
      cpu_wdata    = '0;
      cpu_read     = 1'b0;
      cpu_write    = 1'b0;
      cpu_size     = 2'b00;
      cpu_unsigned = 1'b0;
      mem_read_val = '0;
      mem_ack      = 1'b0;
      test_reset();
      test_store_word();
      test_loads();
      test_store_sub();
      test_errors();
      test_long_ack();
      test_stray_ack();
      test_reset_busy();
`ifdef DMEM_TIMEOUT_EN
      test_timeout();
`else
      test_slow_ack();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
